mem_access_ctrl: RTL and testbench

- Sequencer directly upstream of the 1024x16 unified program/data memory.
- Accepts fetch/load/store requests from the core over a valid/ready handshake, owns the program counter, and drives the memory's address, addressing-mode, write-strobe and write-data pins.
- The memory reads combinationally, writes on the rising edge of its strobe, and writes only at the direct address, so this block generates clean strobe pulses and resolves indirect stores itself with a pointer-read phase.

---
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of the unified 1024x16 program/data memory: owns the PC, issues
// fetch/load/store cycles with a clean write strobe. Optional write trap: MEM_ACCESS_TRAP_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PROG_LIMIT = 401,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ind,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [ADDR_W-1:0] pc,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_addr_mode,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OpFetch = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StRd, StPtr, StWsetup, StWstrobe, StWhold, StResp
  } state_e;

  state_e state_q;
  logic   is_fetch_q;
  logic   trap_q;
  logic   accept;
  logic   trap;

  assign req_ready = (state_q == StIdle) && !pc_load && rst_n;
  assign accept    = req_valid && req_ready;

  // In WSETUP mem_addr already holds the final write address (direct or resolved pointer).
`ifdef MEM_ACCESS_TRAP_EN
  localparam logic [ADDR_W-1:0] ProgLimit = ADDR_W'(PROG_LIMIT);
  assign trap = (mem_addr < ProgLimit);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      is_fetch_q    <= 1'b0;
      trap_q        <= 1'b0;
      pc            <= ADDR_W'(RESET_PC);
      mem_addr      <= '0;
      mem_addr_mode <= 1'b0;
      mem_wr        <= 1'b0;
      mem_wdata     <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      // pc_load wins over the fetch-completion increment.
      if (pc_load) begin
        pc <= pc_value;
      end else if (state_q == StResp && is_fetch_q) begin
        pc <= pc + ADDR_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            is_fetch_q <= (req_op == OpFetch);
            unique case (req_op)
              OpFetch: begin
                mem_addr      <= pc;
                mem_addr_mode <= 1'b0;
                state_q       <= StRd;
              end
              OpLoad: begin
                mem_addr      <= req_addr;
                mem_addr_mode <= req_ind;
                state_q       <= StRd;
              end
              OpStore: begin
                mem_addr      <= req_addr;
                mem_addr_mode <= 1'b0;
                mem_wdata     <= req_wdata;
                state_q       <= req_ind ? StPtr : StWsetup;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= '0;
                state_q   <= StResp;
              end
            endcase
          end
        end
        StRd: begin
          rsp_data      <= mem_rdata;
          rsp_valid     <= 1'b1;
          rsp_err       <= 1'b0;
          mem_addr_mode <= 1'b0;
          state_q       <= StResp;
        end
        StPtr: begin
          mem_addr <= mem_rdata[ADDR_W-1:0];
          state_q  <= StWsetup;
        end
        StWsetup: begin
          // A trapped store still spends the strobe slot so latency is unchanged.
          mem_wr  <= !trap;
          trap_q  <= trap;
          state_q <= StWstrobe;
        end
        StWstrobe: begin
          mem_wr  <= 1'b0;
          state_q <= StWhold;
        end
        StWhold: begin
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_err   <= trap_q;
          state_q   <= StResp;
        end
        StResp: begin
          rsp_valid     <= 1'b0;
          rsp_err       <= 1'b0;
          mem_addr_mode <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand sequences for PC and
// reset corner cases, and random requests against a word-level reference model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [9:0]  req_addr = '0;
  logic        req_ind = 1'b0;
  logic [15:0] req_wdata = '0;
  logic        pc_load = 1'b0;
  logic [9:0]  pc_value = '0;
  logic [9:0]  pc;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [9:0]  mem_addr;
  logic        mem_addr_mode;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  mem_access_ctrl #(
    .ADDR_W    (10),
    .DATA_W    (16),
    .PROG_LIMIT(401),
    .RESET_PC  (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_ind      (req_ind),
    .req_wdata    (req_wdata),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .pc           (pc),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_addr_mode(mem_addr_mode),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench-owned memory: combinational read (mode 1 = indirect), write on strobe rising edge.
  logic [15:0] mem     [1024];
  logic [15:0] ref_mem [1024];
  logic [9:0]  ref_pc;
  int          wr_count = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;

  function automatic logic [15:0] init_val(input int i);
    case (i)
      0:       return 16'h1234;
      1:       return 16'hABCD;
      2:       return 16'h0001;
      5:       return 16'h0505;
      401:     return 16'h00FF;
      402:     return 16'h0191;
      411:     return 16'h019C;
      default: return 16'(i * 40503 + 7);
    endcase
  endfunction

  assign mem_rdata = mem_addr_mode ? mem[mem[mem_addr][9:0]] : mem[mem_addr];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    forever begin
      @(posedge mem_wr);
      mem[mem_addr] = mem_wdata;
      wr_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: word-level semantics of one request.
  logic [15:0] e_data;
  logic        e_err;
  int          e_lat;
  int          e_np;
  logic [9:0]  e_waddr;

  task automatic model(input logic [1:0] op, input logic [9:0] addr, input logic ind,
                       input logic [15:0] wd);
    e_data = 16'h0; e_err = 1'b0; e_np = 0; e_waddr = '0;
    case (op)
      2'd0: begin
        e_data = ref_mem[ref_pc]; e_lat = 2; ref_pc = ref_pc + 10'd1;
      end
      2'd1: begin
        e_data = ind ? ref_mem[ref_mem[addr][9:0]] : ref_mem[addr]; e_lat = 2;
      end
      2'd2: begin
        e_waddr = ind ? ref_mem[addr][9:0] : addr;
        e_lat   = ind ? 5 : 4;
        e_err   = TrapEn && (e_waddr < 10'd401);
        e_np    = e_err ? 0 : 1;
        if (!e_err) ref_mem[e_waddr] = wd;
      end
      default: begin
        e_err = 1'b1; e_lat = 1;
      end
    endcase
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [9:0] addr, input logic ind,
                           input logic [15:0] wd);
    int g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_ind = ind; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Results of the last do_req.
  logic [15:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_np;
  logic        r_stable;
  logic [9:0]  r_waddr;
  logic        r_mode1;

  task automatic do_req(input logic [1:0] op, input logic [9:0] addr, input logic ind,
                        input logic [15:0] wd);
    logic        whist [17];
    logic [9:0]  ahist [17];
    logic [15:0] dhist [17];
    int          base;
    logic        done = 1'b0;
    for (int c = 0; c < 17; c++) begin
      whist[c] = 1'b0; ahist[c] = '0; dhist[c] = '0;
    end
    base = wr_count;
    drive_req(op, addr, ind, wd);
    r_lat = -1; r_data = '0; r_err = 1'b0; r_mode1 = 1'b0;
    for (int c = 1; c < 16 && !done; c++) begin
      whist[c] = mem_wr; ahist[c] = mem_addr; dhist[c] = mem_wdata;
      if (c == 1) r_mode1 = mem_addr_mode;
      if (rsp_valid) begin
        done = 1'b1; r_lat = c; r_data = rsp_data; r_err = rsp_err;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    r_np = wr_count - base;
    r_stable = 1'b0; r_waddr = '0;
    for (int c = 2; c < 16; c++) begin
      if (whist[c]) begin
        r_waddr  = ahist[c];
        r_stable = !whist[c-1] && !whist[c+1] && ahist[c-1] == ahist[c] &&
                   ahist[c+1] == ahist[c] && dhist[c-1] == dhist[c] && dhist[c+1] == dhist[c];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [9:0]  addr;
    logic        ind;
    logic [15:0] wd;
    logic [15:0] ed;
    logic        ee;
    int          el;
    int          enp;
    logic [9:0]  ewa;
    logic        emode;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic bad;
    int   base;
    int   g;
    int   nbad;
    logic [1:0]  op;
    logic [9:0]  a;
    logic        ind;
    logic [15:0] wd;

    vecs[0]  = '{2'd0, 10'd0,   1'b0, 16'h0000, 16'h1234, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[1]  = '{2'd0, 10'd0,   1'b0, 16'h0000, 16'hABCD, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[2]  = '{2'd0, 10'd0,   1'b0, 16'h0000, 16'h0001, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[3]  = '{2'd1, 10'd401, 1'b0, 16'h0000, 16'h00FF, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[4]  = '{2'd1, 10'd402, 1'b1, 16'h0000, 16'h00FF, 1'b0, 2, 0, 10'd0, 1'b1};
    vecs[5]  = '{2'd2, 10'd410, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 4, 1, 10'd410, 1'b0};
    vecs[6]  = '{2'd2, 10'd411, 1'b1, 16'h5A5A, 16'h0000, 1'b0, 5, 1, 10'd412, 1'b0};
    vecs[7]  = '{2'd3, 10'd0,   1'b0, 16'h0000, 16'h0000, 1'b1, 1, 0, 10'd0, 1'b0};
    vecs[8]  = '{2'd1, 10'd410, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[9]  = '{2'd1, 10'd412, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[10] = '{2'd1, 10'd411, 1'b0, 16'h0000, 16'h019C, 1'b0, 2, 0, 10'd0, 1'b0};
    vecs[11] = '{2'd2, 10'd5,   1'b0, 16'h7777, 16'h0000, TrapEn, 4, TrapEn ? 0 : 1,
                 10'd5, 1'b0};
    vecs[12] = '{2'd1, 10'd5,   1'b0, 16'h0000, TrapEn ? 16'h0505 : 16'h7777, 1'b0, 2, 0,
                 10'd0, 1'b0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    ref_pc = 10'd0;

    // Reset state.
    #12;
    check("rst.req_ready", req_ready, 0);
    check("rst.pc", pc, 0);
    check("rst.mem_wr", mem_wr, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.req_ready", req_ready, 1);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].ind, vecs[i].wd);
      do_req(vecs[i].op, vecs[i].addr, vecs[i].ind, vecs[i].wd);
      check($sformatf("vec%0d.data", i), r_data, vecs[i].ed);
      check($sformatf("vec%0d.err", i), r_err, vecs[i].ee);
      check($sformatf("vec%0d.lat", i), r_lat, vecs[i].el);
      check($sformatf("vec%0d.wr_pulses", i), r_np, vecs[i].enp);
      if (vecs[i].op == 2'd2 && vecs[i].enp == 1) begin
        check($sformatf("vec%0d.stable", i), r_stable, 1);
        check($sformatf("vec%0d.waddr", i), r_waddr, vecs[i].ewa);
      end
      if (vecs[i].op == 2'd0 || vecs[i].op == 2'd1)
        check($sformatf("vec%0d.mode", i), r_mode1, vecs[i].emode);
      if (i == 2) check("vec2.pc", pc, 3);
    end

    // PC wrap: request with pc_load high must not be accepted.
    pc_load = 1'b1; pc_value = 10'd1023; req_valid = 1'b1; req_op = 2'd0;
    #1;
    check("pcload.req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    pc_load = 1'b0; req_valid = 1'b0;
    check("pcload.pc", pc, 1023);
    ref_pc = 10'd1023;
    model(2'd0, 10'd0, 1'b0, 16'h0);
    do_req(2'd0, 10'd0, 1'b0, 16'h0);
    check("wrap.data", r_data, e_data);
    check("wrap.pc", pc, 0);

    // pc_load in the FETCH response cycle overrides the increment.
    model(2'd0, 10'd0, 1'b0, 16'h0);
    drive_req(2'd0, 10'd0, 1'b0, 16'h0);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("pcresp.rsp_valid", seen, 1);
    check("pcresp.data", rsp_data, e_data);
    pc_load = 1'b1; pc_value = 10'h050;
    @(posedge clk);
    @(negedge clk);
    pc_load = 1'b0;
    check("pcresp.pc", pc, 10'h050);
    ref_pc = 10'h050;

    // Random requests against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        pc_value = 10'($urandom_range(0, 1023));
        pc_load = 1'b1;
        req_valid = 1'($urandom_range(0, 1));
        #1;
        check("rnd.ready_pcload", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0; req_valid = 1'b0;
        ref_pc = pc_value;
        check("rnd.pcload", pc, ref_pc);
      end
      g = $urandom_range(0, 9);
      op  = (g < 3) ? 2'd0 : (g < 6) ? 2'd1 : (g < 9) ? 2'd2 : 2'd3;
      a   = 10'($urandom_range(0, 1023));
      ind = 1'($urandom_range(0, 1));
      wd  = 16'($urandom);
      model(op, a, ind, wd);
      do_req(op, a, ind, wd);
      check("rnd.data", r_data, e_data);
      check("rnd.err", r_err, e_err);
      check("rnd.lat", r_lat, e_lat);
      check("rnd.wr_pulses", r_np, e_np);
      check("rnd.pc", pc, ref_pc);
      if (e_np == 1) begin
        check("rnd.stable", r_stable, 1);
        check("rnd.waddr", r_waddr, e_waddr);
      end
    end

    // Reset during WSTROBE: strobe already rose, so the write lands; strobe drops at once.
    drive_req(2'd2, 10'd420, 1'b0, 16'h1111);
    g = 0;
    while (!mem_wr && g < 8) begin
      @(negedge clk);
      g++;
    end
    check("rstwr.strobe_seen", mem_wr, 1);
    rst_n = 1'b0;
    #1;
    check("rstwr.mem_wr", mem_wr, 0);
    check("rstwr.req_ready", req_ready, 0);
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1'b1;
    end
    check("rstwr.no_rsp", bad, 0);
    check("rstwr.pc", pc, 0);
    ref_mem[420] = 16'h1111;
    ref_pc = 10'd0;

    // Reset during WSETUP: strobe never rises, no write.
    base = wr_count;
    drive_req(2'd2, 10'd421, 1'b0, 16'h2222);
    rst_n = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_wr) bad = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_wr) bad = 1'b1;
    end
    check("rstsetup.quiet", bad, 0);
    check("rstsetup.no_write", wr_count - base, 0);

    // Normal operation after reset.
    model(2'd1, 10'd420, 1'b0, 16'h0);
    do_req(2'd1, 10'd420, 1'b0, 16'h0);
    check("postrst.data", r_data, e_data);
    check("postrst.lat", r_lat, 2);

    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("final.mem_mismatch_words", nbad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
